// File: rtl/shift_pkg.sv
// Shared types and the one-step shift function for the shift/burst datapath.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_XSR = 2'b01,
    MODE_ROR = 2'b10,
    MODE_SHL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } burst_state_t;

  // Widest register the shift function can serve; callers zero-extend into it.
  localparam int MAX_W = 64;

  // One shift step on the low 'width' bits of data; bits at and above 'width'
  // come back as zero so the caller can simply truncate.
  function automatic logic [MAX_W-1:0] shift_next(
    input logic [MAX_W-1:0] data,
    input int               width,
    input shift_mode_t      mode,
    input logic             shift_in,
    input logic             x_bit
  );
    logic [MAX_W-1:0] res;
    logic [MAX_W-1:0] sr;
    logic [MAX_W-1:0] sl;
    logic             fill;
    res = '0;
    sr  = data >> 1;
    sl  = data << 1;
    case (mode)
      MODE_LSR: fill = shift_in;
      MODE_XSR: fill = x_bit;
      MODE_ROR: fill = data[0];
      default:  fill = shift_in;
    endcase
    for (int i = 0; i < MAX_W; i++) begin
      if (mode == MODE_SHL) begin
        if (i == 0)          res[i] = shift_in;
        else if (i < width)  res[i] = sl[i];
      end else begin
        if (i == width - 1)     res[i] = fill;
        else if (i < width - 1) res[i] = sr[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ext_bit_reg.sv
// Extension bit X: a single flop loaded from X_In, otherwise holding.
module ext_bit_reg (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Load_X,
  input  logic X_In,
  output logic X
);

  logic x_q, x_d;

  // Next value: load when requested, hold otherwise.
  always_comb begin
    x_d = x_q;
    if (Load_X) x_d = X_In;
  end

  // X storage with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) x_q <= 1'b0;
    else          x_q <= x_d;
  end

  assign X = x_q;

endmodule

// File: rtl/shift_reg_burst_unit.sv
// Parametrised shift register with four shift modes, extension bit X and an
// autonomous burst engine performing Burst_Len shifts with Busy/Done handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; Shift_En single steps, Burst_Start launches burst
// ST_SHIFT | one shift per edge using latched mode, counter decrements
// ST_DONE  | Done pulse cycle, still Busy, returns to ST_IDLE
module shift_reg_burst_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Load_X,
  input  logic             X_In,
  input  logic [1:0]       Mode,
  input  logic             Shift_In,
  input  logic             Shift_En,
  input  logic             Burst_Start,
  input  logic [CNT_W-1:0] Burst_Len,
  output logic [WIDTH-1:0] Data_out,
  output logic             X,
  output logic             Shift_out,
  output logic             Busy,
  output logic             Done
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  burst_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shift_mode_t      mode_q, mode_d;
  shift_mode_t      mode_live, mode_eff;
  logic [CNT_W-1:0] len_sat;
  logic [WIDTH-1:0] data_q, data_d;
  logic [MAX_W-1:0] data_ext;
  logic [WIDTH-1:0] shift_res;
  logic             x_q;

  ext_bit_reg u_ext_bit (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Load_X  (Load_X),
    .X_In    (X_In),
    .X       (x_q)
  );

  assign mode_live = shift_mode_t'(Mode);
  assign len_sat   = (Burst_Len > LEN_MAX) ? LEN_MAX : Burst_Len;

  // FSM state register: burst state, remaining-shift counter, latched mode.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_LSR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // FSM next state: Load aborts from any state, otherwise walk the burst.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (Load) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Burst_Start) begin
            mode_d = mode_live;
            if (len_sat != '0) begin
              cnt_d   = len_sat;
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: handshake flags and the effective mode (latched while busy).
  always_comb begin
    Busy      = (state_q != ST_IDLE);
    Done      = (state_q == ST_DONE);
    mode_eff  = Busy ? mode_q : mode_live;
    Shift_out = (mode_eff == MODE_SHL) ? data_q[WIDTH-1] : data_q[0];
  end

  // One-step shift candidate for the current effective mode.
  always_comb begin
    data_ext              = '0;
    data_ext[WIDTH-1:0]   = data_q;
    shift_res             = WIDTH'(shift_next(data_ext, WIDTH, mode_eff, Shift_In, x_q));
  end

  // Data next value: Load, then burst shift, then idle single step, then hold.
  always_comb begin
    data_d = data_q;
    if (Load)
      data_d = D;
    else if (state_q == ST_SHIFT)
      data_d = shift_res;
    else if (state_q == ST_IDLE && Shift_En && !Burst_Start)
      data_d = shift_res;
  end

  // Data register with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign Data_out = data_q;
  assign X        = x_q;

endmodule

// File: tb/tb_shift_reg_burst_unit.sv
module tb_shift_reg_burst_unit;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          Clk;
  logic          Reset_n;
  logic          Load;
  logic [W-1:0]  D;
  logic          Load_X;
  logic          X_In;
  logic [1:0]    Mode;
  logic          Shift_In;
  logic          Shift_En;
  logic          Burst_Start;
  logic [CW-1:0] Burst_Len;
  logic [W-1:0]  Data_out;
  logic          X;
  logic          Shift_out;
  logic          Busy;
  logic          Done;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  shift_reg_burst_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Load        (Load),
    .D           (D),
    .Load_X      (Load_X),
    .X_In        (X_In),
    .Mode        (Mode),
    .Shift_In    (Shift_In),
    .Shift_En    (Shift_En),
    .Burst_Start (Burst_Start),
    .Burst_Len   (Burst_Len),
    .Data_out    (Data_out),
    .X           (X),
    .Shift_out   (Shift_out),
    .Busy        (Busy),
    .Done        (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shifts remaining in the burst plus a pending-done flag.
  logic [W-1:0] m_data;
  logic         m_x;
  logic [1:0]   m_mode;
  int           m_left;
  bit           m_donep;

  function automatic logic [W-1:0] mshift(input logic [W-1:0] d, input logic [1:0] m,
                                          input logic si, input logic xb);
    case (m)
      2'd0:    return (d >> 1) | (W'(si) << (W-1));
      2'd1:    return (d >> 1) | (W'(xb) << (W-1));
      2'd2:    return (d >> 1) | (W'(d[0]) << (W-1));
      default: return W'(d << 1) | W'(si);
    endcase
  endfunction

  function automatic bit m_busy();
    return (m_left > 0) || m_donep;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_data = '0; m_x = 1'b0; m_mode = 2'd0; m_left = 0; m_donep = 1'b0;
    end else begin
      logic nx;
      int   len;
      nx = Load_X ? X_In : m_x;
      if (Load) begin
        m_data = D; m_left = 0; m_donep = 1'b0;
      end else if (m_left > 0) begin
        m_data = mshift(m_data, m_mode, Shift_In, m_x);
        m_left--;
        if (m_left == 0) m_donep = 1'b1;
      end else if (m_donep) begin
        m_donep = 1'b0;
      end else if (Burst_Start) begin
        len    = (int'(Burst_Len) > W) ? W : int'(Burst_Len);
        m_mode = Mode;
        if (len > 0) m_left = len;
        else         m_donep = 1'b1;
      end else if (Shift_En) begin
        m_data = mshift(m_data, Mode, Shift_In, m_x);
      end
      m_x = nx;
    end
  end

  // Compare every cycle against the model, half a period after each edge.
  always @(negedge Clk) begin
    if (Reset_n && cmp_en) begin
      logic [1:0] em;
      em = m_busy() ? m_mode : Mode;
      chk("model_data", Data_out, m_data);
      chk("model_x", X, m_x);
      chk("model_busy", Busy, m_busy());
      chk("model_done", Done, m_donep);
      chk("model_shift_out", Shift_out, (em == 2'd3) ? m_data[W-1] : m_data[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic clr_inputs();
    Load = 0; D = '0; Load_X = 0; X_In = 0; Mode = 2'd0; Shift_In = 0;
    Shift_En = 0; Burst_Start = 0; Burst_Len = '0;
  endtask

  task automatic do_load(input logic [W-1:0] val);
    Load = 1; D = val;
    cyc();
    Load = 0;
  endtask

  // Call right after the start edge; counts Busy/Done cycles until idle.
  task automatic run_burst(input int max, output int bc, output int dc, output logic [W-1:0] dat);
    bc = 0; dc = 0; dat = '0;
    for (int k = 0; k < max; k++) begin
      if (!Busy) break;
      bc++;
      if (Done) begin
        dc++; dat = Data_out; Burst_Start = 0; Shift_En = 0;
      end
      cyc();
    end
    chk("burst_terminates", Busy, 1'b0);
  endtask

  int bc, dc;
  logic [W-1:0] dat;

  initial begin
    clr_inputs();
    Reset_n = 1;
    #1 Reset_n = 0;
    #1;
    chk("reset_data", Data_out, 8'h00);
    chk("reset_x", X, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_done", Done, 1'b0);
    cyc();
    Reset_n = 1;
    cmp_en = 1;
    cyc();

    // Rotate burst
    do_load(8'hA5);
    chk("rot_loaded", Data_out, 8'hA5);
    Mode = 2'd2; Burst_Len = 4; Burst_Start = 1;
    cyc();
    Burst_Start = 0;
    run_burst(20, bc, dc, dat);
    chk("rot_busy_cycles", bc, 5);
    chk("rot_done_cycles", dc, 1);
    chk("rot_data", dat, 8'h5A);

    // X-extension burst, Mode changed mid-burst must be ignored
    Load = 1; D = 8'h80; Load_X = 1; X_In = 1;
    cyc();
    Load = 0; Load_X = 0; X_In = 0;
    chk("xsr_loaded", Data_out, 8'h80);
    chk("xsr_x_loaded", X, 1'b1);
    Mode = 2'd1; Burst_Len = 3; Burst_Start = 1;
    cyc();
    Burst_Start = 0; Mode = 2'd3;
    #1 chk("xsr_so0", Shift_out, 1'b0);
    cyc(); chk("xsr_step1", Data_out, 8'hC0); chk("xsr_so1", Shift_out, 1'b0);
    cyc(); chk("xsr_step2", Data_out, 8'hE0); chk("xsr_so2", Shift_out, 1'b0);
    cyc(); chk("xsr_step3", Data_out, 8'hF0); chk("xsr_x_held", X, 1'b1);
    chk("xsr_done", Done, 1'b1); chk("xsr_busy_done", Busy, 1'b1);
    cyc(); chk("xsr_idle", Busy, 1'b0); chk("xsr_done_off", Done, 1'b0);

    // Single step SHL
    do_load(8'h81);
    Mode = 2'd3; Shift_In = 1; Shift_En = 1;
    #1 chk("single_so", Shift_out, 1'b1);
    cyc();
    Shift_En = 0; Shift_In = 0;
    chk("single_data", Data_out, 8'h03);
    chk("single_busy", Busy, 1'b0);
    chk("single_done", Done, 1'b0);
    cyc(); chk("single_hold", Data_out, 8'h03);

    // Abort with Load on the 3rd shift cycle
    do_load(8'hFF);
    Mode = 2'd0; Shift_In = 0; Burst_Len = 8; Burst_Start = 1;
    cyc();
    Burst_Start = 0;
    cyc(); chk("abort_s1", Data_out, 8'h7F);
    cyc(); chk("abort_s2", Data_out, 8'h3F);
    do_load(8'h3C);
    chk("abort_data", Data_out, 8'h3C);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    cyc(); chk("abort_no_done", Done, 1'b0); chk("abort_hold", Data_out, 8'h3C);

    // Zero-length burst
    Burst_Len = 0; Burst_Start = 1;
    cyc();
    Burst_Start = 0;
    chk("len0_done", Done, 1'b1);
    chk("len0_busy", Busy, 1'b1);
    chk("len0_data", Data_out, 8'h3C);
    cyc();
    chk("len0_done_off", Done, 1'b0);
    chk("len0_idle", Busy, 1'b0);

    // Start/Shift_En/Mode held while busy are ignored
    Mode = 2'd2; Burst_Len = 3; Burst_Start = 1;
    cyc();
    Shift_En = 1; Mode = 2'd3; Shift_In = 1;
    run_burst(20, bc, dc, dat);
    Shift_In = 0;
    chk("busyign_cycles", bc, 4);
    chk("busyign_done", dc, 1);
    chk("busyign_data", dat, 8'h87);

    // Burst_Len above WIDTH saturates
    Mode = 2'd2; Burst_Len = 15; Burst_Start = 1;
    cyc();
    Burst_Start = 0;
    run_burst(30, bc, dc, dat);
    chk("sat_cycles", bc, 9);
    chk("sat_data", dat, 8'h87);

    // Asynchronous reset between edges mid-burst
    do_load(8'hFF);
    Mode = 2'd0; Shift_In = 1; Burst_Len = 8; Burst_Start = 1;
    cyc();
    Burst_Start = 0;
    cyc(); cyc();
    chk("areset_pre_data", Data_out, 8'hFF);
    chk("areset_pre_busy", Busy, 1'b1);
    Reset_n = 0;
    #1;
    chk("areset_data", Data_out, 8'h00);
    chk("areset_x", X, 1'b0);
    chk("areset_busy", Busy, 1'b0);
    chk("areset_done", Done, 1'b0);
    cyc();
    Reset_n = 1; Shift_In = 0;
    cyc(); chk("areset_no_done", Done, 1'b0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      Load        = ($urandom_range(0, 15) == 0);
      D           = W'($urandom);
      Load_X      = ($urandom_range(0, 7) == 0);
      X_In        = 1'($urandom);
      Mode        = 2'($urandom);
      Shift_In    = 1'($urandom);
      Shift_En    = ($urandom_range(0, 2) == 0);
      Burst_Start = ($urandom_range(0, 5) == 0);
      Burst_Len   = CW'($urandom_range(0, 15));
      cyc();
    end
    clr_inputs();
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_burst_unit.md
Name: shift_reg_burst_unit

Overview:
Parametrised successor to the 8-bit multiplier shift register. It adds configurable width, four shift modes, an internal extension bit X, and an autonomous burst engine that performs N consecutive shifts with a Busy/Done handshake. It sits in the datapath of the shift-add multiplier and the serial-conversion labs. It replaces per-cycle Shift_En sequencing in the control FSM with a single Burst_Start command.

Parameters:
WIDTH, 8, register width in bits (minimum 2).
CNT_W, $clog2(WIDTH+1), width of the burst length and counter; holds 0..WIDTH.

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Load  input  1  parallel load of D.
D  input  WIDTH  parallel load data.
Load_X  input  1  load X from X_In.
X_In  input  1  extension bit data.
Mode  input  2  00 LSR, 01 XSR, 10 ROR, 11 SHL.
Shift_In  input  1  serial input for LSR and SHL.
Shift_En  input  1  single-step shift, honoured only when idle.
Burst_Start  input  1  start a burst of Burst_Len shifts.
Burst_Len  input  CNT_W  number of shifts, 0..WIDTH.
Data_out  output  WIDTH  register contents.
X  output  1  extension bit.
Shift_out  output  1  bit about to leave: Data_out[0] for right modes, Data_out[WIDTH-1] for SHL. Uses the latched mode while Busy and the live Mode otherwise.
Busy  output  1  high while a burst is in progress, including the Done cycle.
Done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (Reset_n=0) clears, without waiting for Clk: Data_out=0, X=0, state=IDLE, counter=0, latched mode=00, Busy=0, Done=0.
- Shift modes (one step):
  - LSR: {Shift_In, Data[W-1:1]}.
  - XSR: {X, Data[W-1:1]}. X itself is unchanged.
  - ROR: {Data[0], Data[W-1:1]}.
  - SHL: {Data[W-2:0], Shift_In}.
- Shift_In is sampled live on every shift edge.
- Data register priority, highest first:
  - Load: aborts any burst, state goes to IDLE, no Done pulse.
  - Burst shift: the state is SHIFT.
  - Shift_En: only when IDLE and Burst_Start=0.
  - Hold.
- X: Load_X loads X_In at the edge, independent of Load and shifts, all in the same cycle. Otherwise X holds.
- FSM states:
  - IDLE:
    - Burst_Start=1, Load=0, Burst_Len>0: latch Mode, counter<=Burst_Len, go to SHIFT. No shift occurs on this edge.
    - Burst_Start=1, Load=0, Burst_Len=0: go to DONE.
  - SHIFT: each edge performs one shift and decrements the counter. When counter==1, the last shift is performed and the state goes to DONE.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- Timing: Busy = (state != IDLE). With a start edge at t0, shifts occur at edges t1..tN and Done is high in the cycle after tN.
- While Busy:
  - Burst_Start, Shift_En and Mode changes are ignored.
  - Load still aborts.
- Burst_Len > WIDTH is a caller error and is saturated to WIDTH.
- Reset_n asserted mid-burst aborts immediately; no Done is produced.

Decomposition:
- Package shift_pkg:
  - shift_mode_t enum: MODE_LSR=2'b00, MODE_XSR=2'b01, MODE_ROR=2'b10, MODE_SHL=2'b11.
  - burst_state_t enum: ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module ext_bit_reg: the X flop with async active-low reset and Load_X. It is reused by the multiplier top.
- Shift-mode next-value logic is a function in shift_pkg, parametrised by width via the caller.

Test Plan:
- Reset: hold Reset_n=0 between clock edges with Data_out=8'hFF, Busy=1 -> Data_out=0, X=0, Busy=0, Done=0 before the next edge.
- Rotate burst: Load D=8'hA5, then Burst_Start with Mode=ROR, Burst_Len=4 -> Busy high for 5 cycles, Data_out=8'h5A after the 4th shift edge, Done high in exactly one cycle.
- X-extension burst: Load D=8'h80 and Load_X with X_In=1 in the same cycle, then burst XSR, Burst_Len=3 -> Data_out steps C0, E0, F0; Shift_out=0 each step; X stays 1.
- Single step: idle, Data=8'h81, Mode=SHL, Shift_In=1, one Shift_En pulse -> Shift_out=1 before the edge, Data_out=8'h03 after it, Busy and Done stay 0.
- Abort: Data=8'hFF, LSR burst with Burst_Len=8 and Shift_In=0; on the 3rd shift cycle assert Load with D=8'h3C -> Data_out=8'h3C, Busy=0 next cycle, no Done pulse.
- Edge cases:
  - Burst_Len=0 -> Done pulses one cycle after start, Data_out unchanged.
  - Burst_Start and Shift_En asserted while Busy -> no extra shifts; final count equals the original Burst_Len.
